vpl_div_seq: RTL and testbench

Sequential unsigned restoring divider that pairs with the team's 4-bit carry-lookahead add/subtract unit. It performs division as repeated trial subtraction through a (W+1)-bit add/subtract datapath, producing one quotient bit per clock. It sits beside the combinational adder in the arithmetic block and uses a start/busy/done handshake toward the controlling FSM.

---
 rtl/vpl_arith_pkg.sv | 15 +
 rtl/vpl_addsub_cla.sv | 43 ++++
 rtl/vpl_div_seq.sv | 88 ++++++++
 tb/tb_vpl_div_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/vpl_arith_pkg.sv
// vpl_arith_pkg: shared types, width default and helpers for the arithmetic block.
package vpl_arith_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

    localparam int DIV_W = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vpl_addsub_cla.sv
// vpl_addsub_cla: N-bit carry-lookahead adder/subtractor; sub_i inverts b_i and injects carry-in.
module vpl_addsub_cla #(
    parameter int N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] s_o,
    output logic         cout_o
);

    logic [N-1:0] bx;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    logic         acc;
    logic         pp;

    assign bx = b_i ^ {N{sub_i}};
    assign g  = a_i & bx;
    assign p  = a_i ^ bx;

    // Each carry is expanded as a flat sum of generate/propagate products.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b0;
        c[0] = sub_i;
        for (int i = 0; i < N; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & sub_i);
        end
    end

    assign s_o    = p ^ c[N-1:0];
    assign cout_o = c[N];

endmodule

// File: rtl/vpl_div_seq.sv
// vpl_div_seq: sequential unsigned restoring divider, one quotient bit per clock,
// start/busy/done handshake.
module vpl_div_seq
    import vpl_arith_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o,
    output logic         div_by_zero_o
);

    localparam int CW = clog2(W);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  d_q, d_d;
    logic [W:0]    r_q, r_d;
    logic          dbz_q, dbz_d;
    logic [W:0]    t;
    logic [W:0]    diff;
    logic          no_borrow;
    logic          accept;
    logic          last;

    assign t      = {r_q[W-1:0], q_q[W-1]};
    assign accept = start_i && (state_q != RUN);
    assign last   = cnt_q == CW'(W - 1);

    vpl_addsub_cla #(.N(W + 1)) u_addsub (
        .a_i    (t),
        .b_i    ({1'b0, d_q}),
        .sub_i  (1'b1),
        .s_o    (diff),
        .cout_o (no_borrow)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = accept ? '0 : (state_q == RUN) ? cnt_q + CW'(1) : cnt_q;
        d_d   = accept ? divisor_i : d_q;
        dbz_d = accept ? (divisor_i == '0) : dbz_q;
        q_d   = accept ? dividend_i : (state_q == RUN) ? {q_q[W-2:0], no_borrow} : q_q;
        r_d   = accept ? '0 : (state_q == RUN) ? (no_borrow ? diff : t) : r_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o        = state_q == RUN;
    assign done_o        = state_q == DONE;
    assign quotient_o    = q_q;
    assign remainder_o   = r_q[W-1:0];
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_vpl_div_seq.sv
// tb_vpl_div_seq: directed and exhaustive self-checking bench for vpl_div_seq (W = 4).
module tb_vpl_div_seq;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [3:0] dividend_i = '0;
    logic [3:0] divisor_i = '0;
    logic       busy_o;
    logic       done_o;
    logic [3:0] quotient_o;
    logic [3:0] remainder_o;
    logic       div_by_zero_o;

    int total = 0;
    int bad = 0;

    vpl_div_seq #(.W(4)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_q"}, quotient_o, 0);
        chk({tag, "_r"}, remainder_o, 0);
        chk({tag, "_dbz"}, div_by_zero_o, 0);
    endtask

    // Waits (bounded) for done; returns the number of edges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (!done_o && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic div_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic ez);
        int n;
        tick();
        start_i = 1'b1;
        dividend_i = a;
        divisor_i = b;
        tick();
        start_i = 1'b0;
        wait_done(n);
        chk({tag, "_lat"}, n, 4);
        chk({tag, "_q"}, quotient_o, eq);
        chk({tag, "_r"}, remainder_o, er);
        chk({tag, "_dbz"}, div_by_zero_o, ez);
    endtask

    initial begin
        int n;
        logic saw_done;
        logic [3:0] eq, er;

        start_i = 1'b1;
        dividend_i = 4'd5;
        divisor_i = 4'd1;
        tick();
        idle_outputs("rst1");
        tick();
        idle_outputs("rst2");
        rst_ni = 1'b1;
        start_i = 1'b0;
        tick();
        chk("rst_after_busy", busy_o, 0);

        start_i = 1'b1;
        dividend_i = 4'd13;
        divisor_i = 4'd3;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("d13_busy", busy_o, 1);
            chk("d13_nodone", done_o, 0);
            tick();
        end
        chk("d13_done", done_o, 1);
        chk("d13_busy_off", busy_o, 0);
        chk("d13_q", quotient_o, 4);
        chk("d13_r", remainder_o, 1);
        chk("d13_dbz", div_by_zero_o, 0);
        tick();
        chk("d13_pulse", done_o, 0);
        chk("d13_hold_q", quotient_o, 4);
        chk("d13_hold_r", remainder_o, 1);

        div_op("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        div_op("d2_9", 4'd2, 4'd9, 4'd0, 4'd2, 1'b0);
        div_op("d7_0", 4'd7, 4'd0, 4'hF, 4'd7, 1'b1);

        tick();
        start_i = 1'b1;
        dividend_i = 4'd13;
        divisor_i = 4'd3;
        tick();
        tick();
        dividend_i = 4'd2;
        divisor_i = 4'd1;
        tick();
        start_i = 1'b0;
        wait_done(n);
        chk("ign_lat", n, 2);
        chk("ign_q", quotient_o, 4);
        chk("ign_r", remainder_o, 1);

        tick();
        start_i = 1'b1;
        dividend_i = 4'd14;
        divisor_i = 4'd3;
        tick();
        dividend_i = 4'd11;
        divisor_i = 4'd2;
        wait_done(n);
        chk("b2b1_lat", n, 4);
        chk("b2b1_q", quotient_o, 4);
        chk("b2b1_r", remainder_o, 2);
        tick();
        start_i = 1'b0;
        chk("b2b_busy", busy_o, 1);
        n = 1;
        while (!done_o && n < 20) begin
            tick();
            n++;
        end
        chk("b2b2_gap", n, 5);
        chk("b2b2_q", quotient_o, 5);
        chk("b2b2_r", remainder_o, 1);

        tick();
        start_i = 1'b1;
        dividend_i = 4'd13;
        divisor_i = 4'd3;
        tick();
        start_i = 1'b0;
        tick();
        rst_ni = 1'b0;
        tick();
        idle_outputs("abort");
        rst_ni = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw_done = saw_done | done_o;
        end
        chk("abort_nodone", saw_done, 0);
        div_op("d9_2", 4'd9, 4'd2, 4'd4, 4'd1, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                eq = (b == 0) ? 4'hF : 4'(a / b);
                er = (b == 0) ? 4'(a) : 4'(a % b);
                div_op($sformatf("sw_%0d_%0d", a, b), 4'(a), 4'(b), eq, er, b == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
